// File: rtl/axis_switch_v2.sv
// axis_switch_v2: 1-to-N AXI4-Stream demux with a 2-entry skid buffer, packet-aware channel select and drop counter.
// Define AXIS_SWITCH_V2_BCAST_EN to make cfg_sel=0xFF a broadcast to all channels.
module axis_switch_v2 #(
  parameter int B = 16,
  parameter int N = 16
) (
  input  logic           aclk,
  input  logic           aresetn,
  input  logic [7:0]     cfg_sel,
  input  logic           cfg_we,
  output logic           cfg_busy,
  output logic [7:0]     cfg_cur,
  output logic [31:0]    drop_cnt,
  input  logic           s_axis_tvalid,
  output logic           s_axis_tready,
  input  logic [B-1:0]   s_axis_tdata,
  input  logic           s_axis_tlast,
  output logic [N-1:0]   m_axis_tvalid,
  input  logic [N-1:0]   m_axis_tready,
  output logic [N*B-1:0] m_axis_tdata,
  output logic [N-1:0]   m_axis_tlast
);
  typedef enum logic {IDLE, PKT} state_e;
  state_e state_q, state_d;
  logic rdy_q;
  logic [7:0] pend_q, pend_d, cur_q, cur_d, out_tag_q, out_tag_d, sk_tag_q, sk_tag_d;
  logic busy_q, busy_d, out_v_q, out_v_d, sk_v_q, sk_v_d;
  logic [31:0] drop_q, drop_d;
  logic [B:0] out_q, out_d, sk_q, sk_d;
  logic acc, drop, enq, ret, apply, in_bc, out_bc;
`ifdef AXIS_SWITCH_V2_BCAST_EN
  assign in_bc = cur_q == 8'hFF;
  assign out_bc = out_tag_q == 8'hFF;
`else
  assign in_bc = 1'b0;
  assign out_bc = 1'b0;
`endif
  assign s_axis_tready = rdy_q & ~sk_v_q;
  assign acc = s_axis_tvalid & s_axis_tready;
  assign drop = acc & ~in_bc & (32'(cur_q) >= 32'(N));
  assign enq = acc & ~drop;
  assign ret = out_v_q & (out_bc ? &m_axis_tready : |(m_axis_tvalid & m_axis_tready));
  // Pending select lands between packets: idle with no beat, or right as a tlast beat is taken
  assign apply = busy_q & (acc ? s_axis_tlast : state_q == IDLE);
  assign cfg_busy = busy_q;
  assign cfg_cur = cur_q;
  assign drop_cnt = drop_q;
  always_comb begin
    state_d = acc ? (s_axis_tlast ? IDLE : PKT) : state_q;
    cur_d = apply ? pend_q : cur_q;
    pend_d = cfg_we ? cfg_sel : pend_q;
    busy_d = cfg_we | (busy_q & ~apply);
    drop_d = (drop & ~&drop_q) ? drop_q + 32'd1 : drop_q;
    out_v_d = out_v_q;
    out_d = out_q;
    out_tag_d = out_tag_q;
    sk_v_d = sk_v_q;
    sk_d = sk_q;
    sk_tag_d = sk_tag_q;
    if (!out_v_q || ret) begin
      out_v_d = sk_v_q | enq;
      out_d = sk_v_q ? sk_q : {s_axis_tlast, s_axis_tdata};
      out_tag_d = sk_v_q ? sk_tag_q : cur_q;
      sk_v_d = 1'b0;
    end else if (enq) begin
      sk_v_d = 1'b1;
      sk_d = {s_axis_tlast, s_axis_tdata};
      sk_tag_d = cur_q;
    end
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      rdy_q <= 1'b0;
      pend_q <= '0;
      cur_q <= '0;
      busy_q <= 1'b0;
      drop_q <= '0;
      out_v_q <= 1'b0;
      out_q <= '0;
      out_tag_q <= '0;
      sk_v_q <= 1'b0;
      sk_q <= '0;
      sk_tag_q <= '0;
    end else begin
      state_q <= state_d;
      rdy_q <= 1'b1;
      pend_q <= pend_d;
      cur_q <= cur_d;
      busy_q <= busy_d;
      drop_q <= drop_d;
      out_v_q <= out_v_d;
      out_q <= out_d;
      out_tag_q <= out_tag_d;
      sk_v_q <= sk_v_d;
      sk_q <= sk_d;
      sk_tag_q <= sk_tag_d;
    end
  end
  for (genvar k = 0; k < N; k++) begin : g_ch
    logic hit;
    assign hit = out_v_q & (out_bc | out_tag_q == 8'(k));
    assign m_axis_tvalid[k] = hit;
    assign m_axis_tlast[k] = hit & out_q[B];
    assign m_axis_tdata[k*B +: B] = hit ? out_q[B-1:0] : '0;
  end
endmodule

// File: doc/axis_switch_v2.md
# axis_switch_v2

Parametrised 1-to-N AXI4-Stream demultiplexer with full backpressure, packet-aware channel switching and a drop counter for unrouted traffic. It sits between a single stream source (DDS/readout chain) and N downstream consumers. It replaces the fixed 16-output, always-ready switch with a registered datapath that honours `m_axis_tready` and never splits a packet across outputs.

## Interface
Parameters:
- `B`, 16, data width in bits.
- `N`, 16, number of output channels (1..255).

Ports:
- `aclk`  in  1  single clock for all logic.
- `aresetn`  in  1  asynchronous, active-low reset.
- `cfg_sel`  in  8  requested output channel.
- `cfg_we`  in  1  one-cycle strobe that loads `cfg_sel` into the pending-select register.
- `cfg_busy`  out  1  high while a pending select has not yet been applied.
- `cfg_cur`  out  8  channel currently applied to incoming beats.
- `drop_cnt`  out  32  saturating count of beats dropped as unrouted.
- `s_axis_tvalid`  in  1  input beat valid.
- `s_axis_tready`  out  1  input ready.
- `s_axis_tdata`  in  B  input data.
- `s_axis_tlast`  in  1  end of packet.
- `m_axis_tvalid`  out  N  per-channel valid.
- `m_axis_tready`  in  N  per-channel ready.
- `m_axis_tdata`  out  N*B  channel k occupies bits [k*B +: B].
- `m_axis_tlast`  out  N  per-channel last.

## Operation
- **Packet FSM**, states IDLE and PKT.
  - IDLE → PKT on an accepted beat with `tlast`=0.
  - PKT → IDLE on an accepted beat with `tlast`=1.
  - An accepted `tlast`=1 beat in IDLE stays in IDLE (single-beat packet).
- **Channel select.**
  - `cfg_we` writes the pending register and sets `cfg_busy`.
  - The pending value transfers to `cfg_cur` on the first cycle the FSM is in IDLE with no beat being accepted. It also transfers on the cycle after the beat carrying `tlast` is accepted.
  - `cfg_busy` clears in the same cycle `cfg_cur` updates.
  - A second `cfg_we` before application overwrites the pending value; last write wins.
  - If `cfg_we` and application coincide, the new value remains pending.
- **Destination tagging.** Each accepted beat is tagged with `cfg_cur` at acceptance. Buffered beats keep their tag after `cfg_cur` changes.
- **Buffering.** Two-entry skid buffer: an output register plus a skid register.
  - `s_axis_tready` = skid register empty.
  - The output register drives only the tagged channel: `tvalid`, `tdata` and `tlast` are asserted there.
  - All other channels hold `tvalid`=0, `tdata`=0 and `tlast`=0.
  - A beat retires when the tagged channel's `m_axis_tready` is high.
- **Unrouted beats** (tag ≥ N, excluding the broadcast code when enabled).
  - These are accepted normally and discarded at input; they never enter the buffer.
  - `drop_cnt` increments by 1 per dropped beat and saturates at 0xFFFFFFFF.
- **Throughput.** One beat per cycle when the destination is continuously ready.

## Timing
- Reset values:
  - All `m_axis_*` outputs are 0.
  - `s_axis_tready`=0; it rises on the first `aclk` edge after `aresetn` deasserts.
  - `cfg_cur`=0, `cfg_busy`=0, `drop_cnt`=0, FSM in IDLE, both buffer entries empty.
- Latency: a beat accepted at edge t is presented on its output after edge t (1 cycle), given an empty buffer.
- Backpressure:
  - When the destination deasserts ready, the buffer holds up to 2 beats.
  - `s_axis_tready` falls the cycle after the skid register fills.
  - `s_axis_tready` returns 1 cycle after the first retirement.
- Output `tvalid`/`tdata` are stable while `tvalid`=1 and `tready`=0, per the AXI4-Stream rule.
- Reset mid-packet: buffered beats are discarded and the FSM returns to IDLE. No partial packet is emitted afterwards.
- `cfg_cur` change never reroutes an already-accepted beat.

## Configuration
- Macro: `AXIS_SWITCH_V2_BCAST_EN`.
- **Defined:**
  - `cfg_sel`=0xFF is broadcast: every output channel asserts `tvalid` with identical `tdata`/`tlast`.
  - A broadcast beat retires only in a cycle where all N `m_axis_tready` bits are high.
  - Broadcast beats are not counted in `drop_cnt`.
- **Undefined:** 0xFF is an ordinary out-of-range value. Its beats are dropped and counted, and the broadcast logic is absent.

## Test plan
- **Routing:** after reset, `cfg_sel`=3 with `cfg_we`, all readies 1, stream 0x0001..0x0008 with `tlast` on the 8th beat → ch3 emits the 8 beats 1 cycle after input; other channels stay at `tvalid`=0, `tdata`=0; `cfg_cur`=3.
- **Mid-packet switch:** in a 6-beat packet to ch2, write `cfg_sel`=5 after beat 2 → beats 3..6 still go to ch2; `cfg_busy`=1 until the cycle after beat 6 is accepted; the next packet goes to ch5.
- **Backpressure:** with ch0 `tready` forced low, stream 5 beats → exactly 2 beats accepted and `s_axis_tready`=0; release ready → all 5 beats appear in order with no loss or duplication.
- **Unrouted traffic:** with N=16, `cfg_sel`=20, send 10 beats → all outputs idle, `s_axis_tready` stays 1, `drop_cnt`=10.
- **Broadcast (macro on):** `cfg_sel`=0xFF, send 0xABCD with ch7 `tready` low → all channels show 0xABCD and hold it; the beat retires on the cycle ch7 goes high.
- **Reset mid-operation:** assert `aresetn` low while the buffer holds 2 beats → all outputs are 0 immediately and `drop_cnt`=0; after release, no stale beat appears.
